// File: rtl/vdp_host_port.sv
// rtl/vdp_host_port.sv - CPU-side VDP port: control protocol, registers, VRAM access slot, status/irq
module vdp_host_port #(
  parameter int VRAM_SIZE = 16384,
  parameter int NUM_REGS  = 8,
  localparam int AW = $clog2(VRAM_SIZE),
  localparam int RW = $clog2(NUM_REGS)
) (
  input  logic                  pxclk,
  input  logic                  reset,
  input  logic                  wr_tick,
  input  logic                  rd_tick,
  input  logic                  mode,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic [8*NUM_REGS-1:0] regs,
  output logic                  vram_req,
  output logic                  vram_we,
  output logic [AW-1:0]         vram_addr,
  output logic [7:0]            vram_wdata,
  input  logic                  vram_grant,
  input  logic [7:0]            vram_rdata,
  input  logic                  frame_tick,
  input  logic                  coll_tick,
  input  logic                  fifth_tick,
  input  logic [4:0]            fifth_num,
  output logic                  irq,
  output logic                  ovr_tick
);

  typedef enum logic [1:0] {S_IDLE, S_REQ_RD, S_REQ_WR, S_WAIT_DATA} state_t;
  state_t state, state_next;

  logic [7:0]    latch;
  logic          latch_full;
  logic [AW-1:0] addr;
  logic [7:0]    rd_buf;
  logic          f_flag, s5_flag, c_flag;
  logic [4:0]    fifth_num_reg;

  logic          data_wr, data_rd, ctl_wr, stat_rd;
  logic          ctl_second, addr_set, pf_req, reg_ok;
  logic          rd_req, busy, issue_wr, issue_rd, drop, granted;
  logic [13:0]   ctl_word;
  logic [AW-1:0] ctl_addr;
  logic [7:0]    status_byte;

  assign data_wr    = wr_tick & ~mode;
  assign data_rd    = rd_tick & ~mode;
  assign ctl_wr     = wr_tick & mode;
  assign stat_rd    = rd_tick & mode;
  assign ctl_second = ctl_wr & latch_full;
  assign addr_set   = ctl_second & ~din[7];
  assign pf_req     = addr_set & ~din[6];
  assign reg_ok     = ({1'b0, din[5:0]} < 7'(NUM_REGS));
  assign ctl_word   = {din[5:0], latch};
  assign ctl_addr   = ctl_word[AW-1:0];

  // Only one access may be in flight; anything arriving while busy is dropped and flagged.
  assign rd_req   = data_rd | pf_req;
  assign busy     = (state != S_IDLE);
  assign issue_wr = data_wr & ~busy;
  assign issue_rd = rd_req & ~data_wr & ~busy;
  assign drop     = busy & (data_wr | rd_req);
  assign granted  = vram_req & vram_grant;

  assign vram_req    = (state == S_REQ_RD) || (state == S_REQ_WR);
  assign vram_we     = (state == S_REQ_WR);
  assign status_byte = {f_flag, s5_flag, c_flag, fifth_num_reg};
  assign dout        = data_rd ? rd_buf : (stat_rd ? status_byte : 8'h00);

  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (issue_wr)      state_next = S_REQ_WR;
        else if (issue_rd) state_next = S_REQ_RD;
      end
      S_REQ_RD:    if (vram_grant) state_next = S_WAIT_DATA;
      S_REQ_WR:    if (vram_grant) state_next = S_IDLE;
      S_WAIT_DATA: state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) begin
      latch         <= 8'h00;
      latch_full    <= 1'b0;
      regs          <= '0;
      addr          <= '0;
      rd_buf        <= 8'h00;
      vram_addr     <= '0;
      vram_wdata    <= 8'h00;
      f_flag        <= 1'b0;
      s5_flag       <= 1'b0;
      c_flag        <= 1'b0;
      fifth_num_reg <= 5'd0;
      irq           <= 1'b0;
      ovr_tick      <= 1'b0;
    end else begin
      ovr_tick <= drop;
      irq      <= f_flag & regs[13];

      if (data_wr || data_rd || stat_rd) begin
        latch_full <= 1'b0;
      end else if (ctl_wr) begin
        if (!latch_full) latch <= din;
        latch_full <= ~latch_full;
      end

      if (ctl_second && din[7] && reg_ok)
        regs[{din[RW-1:0], 3'b000} +: 8] <= latch;

      // A CPU address-set overrides the post-grant increment of the same cycle.
      if (addr_set)     addr <= ctl_addr;
      else if (granted) addr <= addr + AW'(1);

      if (issue_wr) begin
        vram_addr  <= addr;
        vram_wdata <= din;
      end else if (issue_rd) begin
        vram_addr <= pf_req ? ctl_addr : addr;
      end

      if (data_wr)                    rd_buf <= din;
      else if (state == S_WAIT_DATA)  rd_buf <= vram_rdata;

      // Set events beat the clear of a coincident status read.
      f_flag  <= frame_tick | (f_flag & ~stat_rd);
      c_flag  <= coll_tick | (c_flag & ~stat_rd);
      s5_flag <= fifth_tick | (s5_flag & ~stat_rd);
      if (fifth_tick && !s5_flag) fifth_num_reg <= fifth_num;
    end
  end

endmodule

// File: tb/tb_vdp_host_port.sv
// tb/tb_vdp_host_port.sv - directed self-checking bench for vdp_host_port
module tb_vdp_host_port;
  logic        pxclk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_tick = 1'b0, rd_tick = 1'b0, mode = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic [63:0] regs;
  logic        vram_req, vram_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_grant = 1'b0;
  logic [7:0]  vram_rdata = 8'h00;
  logic        frame_tick = 1'b0, coll_tick = 1'b0, fifth_tick = 1'b0;
  logic [4:0]  fifth_num = 5'd0;
  logic        irq, ovr_tick;

  int total = 0;
  int bad = 0;
  int wr_count = 0;
  int wc0;
  logic [7:0] mem [16384];
  logic [7:0] sv;

  vdp_host_port #(.VRAM_SIZE(16384), .NUM_REGS(8)) dut (
    .pxclk(pxclk), .reset(reset), .wr_tick(wr_tick), .rd_tick(rd_tick), .mode(mode),
    .din(din), .dout(dout), .regs(regs), .vram_req(vram_req), .vram_we(vram_we),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_grant(vram_grant),
    .vram_rdata(vram_rdata), .frame_tick(frame_tick), .coll_tick(coll_tick),
    .fifth_tick(fifth_tick), .fifth_num(fifth_num), .irq(irq), .ovr_tick(ovr_tick)
  );

  always #5 pxclk = ~pxclk;

  // VRAM model: read data is a fixed pattern of the address, returned the cycle after grant.
  always @(posedge pxclk) begin
    if (vram_req && vram_grant) begin
      if (vram_we) begin
        mem[vram_addr] <= vram_wdata;
        wr_count <= wr_count + 1;
      end else begin
        vram_rdata <= vram_addr[7:0] ^ 8'h5A;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pxclk);
    #1;
  endtask

  task automatic ctl_write(input logic [7:0] b);
    mode = 1'b1; din = b; wr_tick = 1'b1;
    step();
    wr_tick = 1'b0;
  endtask

  task automatic data_write(input logic [7:0] b);
    mode = 1'b0; din = b; wr_tick = 1'b1;
    step();
    wr_tick = 1'b0;
  endtask

  task automatic data_read(output logic [7:0] v);
    mode = 1'b0; rd_tick = 1'b1;
    #1 v = dout;
    step();
    rd_tick = 1'b0;
  endtask

  task automatic status_read(output logic [7:0] v);
    mode = 1'b1; rd_tick = 1'b1;
    #1 v = dout;
    step();
    rd_tick = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge pxclk);
    #1;
    check("rst_regs", regs, 64'h0);
    check("rst_req", vram_req, 1'b0);
    check("rst_we", vram_we, 1'b0);
    check("rst_vaddr", vram_addr, 14'h0);
    check("rst_wdata", vram_wdata, 8'h00);
    check("rst_irq", irq, 1'b0);
    check("rst_ovr", ovr_tick, 1'b0);
    check("rst_dout", dout, 8'h00);
    reset = 1'b0;
    step();
    status_read(sv);
    check("rst_status", sv, 8'h00);

    ctl_write(8'h20); ctl_write(8'h81);
    check("reg1", regs[15:8], 8'h20);
    ctl_write(8'h55); ctl_write(8'h87);
    check("reg7", regs[63:56], 8'h55);
    ctl_write(8'h11); ctl_write(8'hBF);
    check("reg_oob", regs, 64'h5500_0000_0000_2000);
    check("reg_noreq", vram_req, 1'b0);

    vram_grant = 1'b1;
    ctl_write(8'h00); ctl_write(8'h48);
    check("wsetup_noreq", vram_req, 1'b0);
    data_write(8'hA1);
    check("w1_req", vram_req, 1'b1);
    check("w1_we", vram_we, 1'b1);
    check("w1_addr", vram_addr, 14'h0800);
    check("w1_data", vram_wdata, 8'hA1);
    step();
    data_write(8'hA2);
    check("w2_addr", vram_addr, 14'h0801);
    step();
    check("mem800", mem[14'h0800], 8'hA1);
    check("mem801", mem[14'h0801], 8'hA2);
    check("wcount2", wr_count, 2);
    data_read(sv);
    check("rdbuf_wr", sv, 8'hA2);
    check("pf802_addr", vram_addr, 14'h0802);
    check("pf802_we", vram_we, 1'b0);
    step(); step();
    data_read(sv);
    check("rd802", sv, 8'h58);
    step(); step(); step();
    vram_grant = 1'b0;

    ctl_write(8'hFF); ctl_write(8'h3F);
    check("pf3fff_req", vram_req, 1'b1);
    check("pf3fff_addr", vram_addr, 14'h3FFF);
    repeat (5) step();
    check("hold_req", vram_req, 1'b1);
    check("hold_addr", vram_addr, 14'h3FFF);
    vram_grant = 1'b1;
    step();
    vram_grant = 1'b0;
    step();
    data_read(sv);
    check("rd3fff", sv, 8'hA5);
    check("ovr_none", ovr_tick, 1'b0);
    check("wrap_addr", vram_addr, 14'h0000);
    check("wrap_req", vram_req, 1'b1);
    vram_grant = 1'b1;
    step(); step();
    vram_grant = 1'b0;

    wc0 = wr_count;
    data_write(8'h11);
    check("busy_addr", vram_addr, 14'h0001);
    data_write(8'h22);
    check("ovr_pulse", ovr_tick, 1'b1);
    check("busy_wdata", vram_wdata, 8'h11);
    step();
    check("ovr_end", ovr_tick, 1'b0);
    vram_grant = 1'b1;
    step();
    vram_grant = 1'b0;
    check("one_write", wr_count, wc0 + 1);
    check("mem1", mem[14'h0001], 8'h11);
    check("busy_done", vram_req, 1'b0);
    data_read(sv);
    check("rdbuf_2nd", sv, 8'h22);
    check("pf2_addr", vram_addr, 14'h0002);
    vram_grant = 1'b1;
    step(); step();
    vram_grant = 1'b0;

    check("irq_idle", irq, 1'b0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("irq_lag", irq, 1'b0);
    step();
    check("irq_set", irq, 1'b1);
    status_read(sv);
    check("status_f", sv, 8'h80);
    step();
    check("irq_clr", irq, 1'b0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    check("irq_set2", irq, 1'b1);
    mode = 1'b1; rd_tick = 1'b1; frame_tick = 1'b1;
    #1 check("status_coin", dout, 8'h80);
    step();
    rd_tick = 1'b0; frame_tick = 1'b0;
    step();
    check("irq_coin", irq, 1'b1);
    status_read(sv);
    check("status_f2", sv, 8'h80);
    step(); step();
    check("irq_clr2", irq, 1'b0);

    fifth_tick = 1'b1; fifth_num = 5'd3;
    step();
    fifth_num = 5'd9;
    step();
    fifth_tick = 1'b0;
    status_read(sv);
    check("status_5s", sv, 8'h43);
    coll_tick = 1'b1;
    step();
    coll_tick = 1'b0;
    status_read(sv);
    check("status_c", sv, 8'h23);
    status_read(sv);
    check("status_clr", sv, 8'h03);

    ctl_write(8'h12);
    status_read(sv);
    ctl_write(8'h34); ctl_write(8'h85);
    check("latch_clr", regs, 64'h5500_3400_0000_2000);

    wc0 = wr_count;
    data_write(8'h77);
    check("mid_req", vram_req, 1'b1);
    #2 reset = 1'b1;
    #1 check("mid_drop", vram_req, 1'b0);
    vram_grant = 1'b1;
    step();
    reset = 1'b0;
    step(); step();
    vram_grant = 1'b0;
    check("mid_nowrite", wr_count, wc0);
    check("mid_regs", regs, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
